// File: rtl/logic_unit_stream_stage.sv
// Stream front-end for the logical unit: assembles A and B from narrow beats,
// applies AND/OR/XOR/XNOR, and offers the registered result with zero/parity flags.
module logic_unit_stream_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / BUS_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        OUT    = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_XNOR = 2'b11
    } op_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] a, a_d;
    logic [WIDTH-1:0] b, b_d;
    op_t              op, op_d;
    logic             valid_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             parity_d;
    logic             ready_d;
    logic             busy_d;
    logic             beat;
    logic [WIDTH-1:0] res;

    // Bitwise operation on the assembled operands
    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            default: res = '0;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        a_d      = a;
        b_d      = b;
        op_d     = op;
        valid_d  = out_valid;
        result_d = out_result;
        zero_d   = out_zero;
        parity_d = out_parity;
        beat     = in_valid && in_ready;

        case (state)
            LOAD_A: begin
                if (beat) begin
                    a_d[cnt * BUS_W +: BUS_W] = in_data;
                    if (cnt == '0) begin
                        op_d = op_t'(in_op);
                    end
                    if (cnt == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (beat) begin
                    b_d[cnt * BUS_W +: BUS_W] = in_data;
                    if (cnt == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                result_d = res;
                zero_d   = ~|res;
                parity_d = ^res;
                valid_d  = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                // Handoff cycle never accepts input; loading resumes next cycle
                if (out_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d  = !((state_d == LOAD_A) && (cnt_d == '0));
    end

    // State, operand and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            cnt        <= '0;
            a          <= '0;
            b          <= '0;
            op         <= OP_AND;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            a          <= a_d;
            b          <= b_d;
            op         <= op_d;
            out_valid  <= valid_d;
            out_result <= result_d;
            out_zero   <= zero_d;
            out_parity <= parity_d;
            in_ready   <= ready_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_logic_unit_stream_stage.sv
// Directed bench for logic_unit_stream_stage: vector table plus multi-cycle corner sequences.
module tb_logic_unit_stream_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_parity;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic        exp_par;
    } vec_t;

    vec_t vecs[9];

    logic_unit_stream_stage #(.WIDTH(32), .BUS_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; called #1 after a rising edge
    task automatic send_beat(input logic [7:0] d, input logic [1:0] o);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = o;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: in_ready stayed %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full transaction: 4 A beats, 4 B beats, result check, optional hold, handoff
    task automatic run_txn(input string tag, input vec_t v, input int gaps, input int hold);
        logic [7:0] d;
        logic [1:0] o;
        out_ready = (hold == 0);
        for (int i = 0; i < 8; i++) begin
            d = (i < 4) ? v.a[i*8 +: 8] : v.b[(i-4)*8 +: 8];
            o = (i == 0) ? v.op : ~v.op;
            send_beat(d, o);
            if (gaps != 0 && i != 7) begin
                @(posedge clk); #1;
            end
        end
        check({tag, " exec_valid"}, 32'(out_valid), 32'd0);
        check({tag, " exec_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " result"}, out_result, v.exp_res);
        check({tag, " zero"}, 32'(out_zero), 32'(v.exp_zero));
        check({tag, " parity"}, 32'(out_parity), 32'(v.exp_par));
        check({tag, " out_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold_result"}, out_result, v.exp_res);
            check({tag, " hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " handoff_valid"}, 32'(out_valid), 32'd0);
        check({tag, " handoff_ready"}, 32'(in_ready), 32'd1);
        check({tag, " handoff_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'hCA981547, 32'h35E7EAB9, 2'b10, 32'hFF7FFFFE, 1'b0, 1'b0};
        vecs[1] = '{32'h3567EAB8, 32'h3567EAB9, 2'b10, 32'h00000001, 1'b0, 1'b1};
        vecs[2] = '{32'h3567EAB9, 32'h3567EAB9, 2'b10, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'hF000F000, 1'b0, 1'b0};
        vecs[4] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[5] = '{32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 32'hF00FF00F, 1'b0, 1'b0};
        vecs[6] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 2'b00, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h00000001, 32'h80000000, 2'b01, 32'h80000001, 1'b0, 1'b0};
        vecs[8] = '{32'h00000007, 32'h00000000, 2'b10, 32'h00000007, 1'b0, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_op     = 2'b00;
        out_ready = 1'b1;
        #12;
        check("rst_valid",  32'(out_valid),  32'd0);
        check("rst_result", out_result,      32'd0);
        check("rst_zero",   32'(out_zero),   32'd0);
        check("rst_parity", 32'(out_parity), 32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", 32'(in_ready), 32'd1);

        // Table: every op/flag case, gapless, out_ready high
        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], 0, 0);
        end

        // Stream gaps on every beat
        run_txn("gap_xor", vecs[0], 1, 0);
        run_txn("gap_xnor", vecs[5], 1, 0);

        // Backpressure for 5 cycles
        run_txn("bp_and", vecs[3], 0, 5);

        // Reset after 3 beats of A
        send_beat(8'hAA, 2'b01);
        send_beat(8'hBB, 2'b01);
        send_beat(8'hCC, 2'b01);
        check("mid_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #2;
        check("midrst_busy",   32'(busy),      32'd0);
        check("midrst_valid",  32'(out_valid), 32'd0);
        check("midrst_ready",  32'(in_ready),  32'd1);
        check("midrst_result", out_result,     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn("post_rst", vecs[0], 0, 0);
        run_txn("post_rst2", vecs[1], 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
